axis_protocol_checker: RTL
==========================

# axis_protocol_checker

Synthesizable, parametrised AXI4-Stream protocol checker that passively taps any stream link and reports violations at run time. It succeeds the formal-only stream property set with sticky error flags, first-error capture, packet-framing tracking (TID/TDEST interleave and maximum packet length), and beat/packet statistics. It sits beside any stream interface in silicon or simulation, has no outputs onto the bus, and never back-pressures.

## Interface
- BYTE_WIDTH, 4, TDATA bytes (≥1); TSTRB/TKEEP width = BYTE_WIDTH
- ID_WIDTH, 0, TID width; 0 = absent (port is 1 bit, ignored)
- DEST_WIDTH, 0, TDEST width; 0 = absent (port is 1 bit, ignored)
- USER_WIDTH, 0, TUSER width; 0 = absent (port is 1 bit, ignored)
- MAX_BEATS, 0, maximum beats per packet; 0 disables the length check
- ALLOW_INTERLEAVE, 1, 0 = TID/TDEST must stay constant within a packet
- CNT_WIDTH, 32, width of the statistics counters
- STALL_LIMIT, 1024, stall cycles tolerated (used only with the macro)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- tvalid, tready, tlast  in  1  tapped handshake/framing
- tdata  in  8*BYTE_WIDTH; tstrb, tkeep  in  BYTE_WIDTH
- tid  in  max(1,ID_WIDTH); tdest  in  max(1,DEST_WIDTH); tuser  in  max(1,USER_WIDTH)
- err_clear  in  1  synchronous clear of err_flags/err_first
- err_flags  out  6  sticky violation bits (index list below)
- err_first  out  6  one-hot of the earliest violation since the last clear
- err_pulse  out  1  high one cycle after any new violation
- beat_count, pkt_count  out  CNT_WIDTH  saturating statistics
- in_packet  out  1  high between a non-last beat and the closing TLAST beat

## Operation
- Error bits: 0 VALID_DROP, 1 PAYLOAD_UNSTABLE, 2 STRB_NO_KEEP, 3 PKT_TOO_LONG, 4 ID_INTERLEAVE, 5 STALL_TIMEOUT.
- A previous-cycle snapshot (tvalid, tready, payload) is registered; prev_ok is cleared by reset and set after the first post-reset edge.
- VALID_DROP: prev_ok && prev tvalid && !prev tready && !tvalid.
- PAYLOAD_UNSTABLE: prev_ok && prev tvalid && !prev tready && any present field changed (tdata, tstrb, tkeep, tlast, tid/tdest/tuser only if width>0).
- STRB_NO_KEEP: tvalid && |(tstrb & ~tkeep).
- Framing FSM, states IDLE and IN_PKT, advancing only on handshake (tvalid && tready): tlast beat → IDLE; non-last beat → IN_PKT, latching tid/tdest on the IDLE→IN_PKT beat. in_packet = (state == IN_PKT).
- ID_INTERLEAVE: ALLOW_INTERLEAVE=0, state IN_PKT, handshake whose tid/tdest differ from latched values. Latches are kept.
- PKT_TOO_LONG: MAX_BEATS>0 and handshake with pkt_beats == MAX_BEATS; pkt_beats counts beats in the current packet, resets on tlast handshake, saturates.
- Counters: beat_count +1 per handshake, pkt_count +1 per tlast handshake; both saturate at all-ones and never wrap. err_clear does not affect counters.
- err_first is loaded only while it is zero; simultaneous new violations load all of them.

## Timing
- Reset (asynchronous): every output, FSM (IDLE), snapshot, and counter is 0.
- Detection latency is one cycle: a violation sampled at edge k is visible in err_flags/err_pulse after edge k. err_pulse is asserted only for bits that were 0 before.
- err_clear at edge k clears flags; a violation sampled at the same edge is set (new error wins), and err_first takes it.
- The first edge after reset release checks only STRB_NO_KEEP and framing.

## Configuration
- AXIS_CHECKER_STALL_TIMEOUT_EN defined: a counter of consecutive tvalid && !tready cycles (cleared on handshake or !tvalid, saturating) sets bit 5 when it reaches STALL_LIMIT.
- Not defined: no counter logic, and bit 5 is tied to 0.

## Structure
- axis_checker_pkg holds the error index localparams (ERR_VALID_DROP … ERR_STALL_TIMEOUT), ERR_COUNT = 6, and the FSM state typedef.
- Sub-module axis_pkt_tracker holds the framing FSM, tid/tdest latch, pkt_beats, and the interleave/length checks. The top level holds the snapshot, error register, and statistics.

## Test plan
- 10 clean packets of 4 beats each with random tready → err_flags=0, beat_count=40, pkt_count=10, in_packet=0 at the end.
- tvalid=1, tready=0 for 2 cycles, then tvalid=0 → err_flags=6'b000001, err_pulse for 1 cycle, err_first=6'b000001.
- Stalled beat changes tdata 0xA5A5A5A5→0x5A5A5A5A plus tstrb=4'b0011, tkeep=4'b0001 at the same edge → bits 1 and 2 set, and err_first has both.
- MAX_BEATS=4, 5-beat packet → bit 3 on the 5th handshake. ALLOW_INTERLEAVE=0, tid 2→3 mid-packet → bit 4.
- err_clear concurrent with a new STRB_NO_KEEP → err_flags=6'b000100 afterwards. Reset mid-packet → all outputs 0 and FSM in IDLE.
- Macro on, STALL_LIMIT=8: 8 stall cycles → bit 5 set. Macro off: 100 stall cycles → bit 5 stays 0.

Source files
------------

// File: rtl/axis_checker_pkg.sv
// rtl/axis_checker_pkg.sv - shared error indices, FSM state type and width helper for the stream checker
package axis_checker_pkg;

    localparam int ERR_VALID_DROP       = 0;
    localparam int ERR_PAYLOAD_UNSTABLE = 1;
    localparam int ERR_STRB_NO_KEEP     = 2;
    localparam int ERR_PKT_TOO_LONG     = 3;
    localparam int ERR_ID_INTERLEAVE    = 4;
    localparam int ERR_STALL_TIMEOUT    = 5;
    localparam int ERR_COUNT            = 6;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_t;

    // Optional sideband fields keep a 1-bit port when absent.
    function automatic int max1(input int w);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/axis_protocol_checker_if.sv
// rtl/axis_protocol_checker_if.sv - stream link bundle with master, slave and passive monitor views
interface axis_protocol_checker_if #(
    parameter int BYTE_WIDTH = 4,
    parameter int ID_WIDTH   = 0,
    parameter int DEST_WIDTH = 0,
    parameter int USER_WIDTH = 0
);
    import axis_checker_pkg::*;

    localparam int IW = max1(ID_WIDTH);
    localparam int DW = max1(DEST_WIDTH);
    localparam int UW = max1(USER_WIDTH);

    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [8*BYTE_WIDTH-1:0] tdata;
    logic [BYTE_WIDTH-1:0]   tstrb;
    logic [BYTE_WIDTH-1:0]   tkeep;
    logic [IW-1:0]           tid;
    logic [DW-1:0]           tdest;
    logic [UW-1:0]           tuser;

    modport master (
        output tvalid, tlast, tdata, tstrb, tkeep, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tlast, tdata, tstrb, tkeep, tid, tdest, tuser,
        output tready
    );

    modport monitor (
        input tvalid, tready, tlast, tdata, tstrb, tkeep, tid, tdest, tuser
    );

endinterface

// File: rtl/axis_pkt_tracker.sv
// rtl/axis_pkt_tracker.sv - packet framing FSM with TID/TDEST interleave and packet length checks
module axis_pkt_tracker
    import axis_checker_pkg::*;
#(
    parameter int ID_WIDTH         = 0,
    parameter int DEST_WIDTH       = 0,
    parameter int MAX_BEATS        = 0,
    parameter int ALLOW_INTERLEAVE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hs,
    input  logic                       last,
    input  logic [max1(ID_WIDTH)-1:0]  tid,
    input  logic [max1(DEST_WIDTH)-1:0] tdest,
    output logic                       in_packet,
    output logic                       err_interleave,
    output logic                       err_too_long
);

    localparam int IW = max1(ID_WIDTH);
    localparam int DW = max1(DEST_WIDTH);
    localparam int BW = $clog2(MAX_BEATS + 2);
    // Stopping at MAX_BEATS keeps every further beat of an overlong packet flagged.
    localparam logic [BW-1:0] BEAT_SAT = (MAX_BEATS > 0) ? BW'(MAX_BEATS) : '1;

    pkt_state_t    state;
    pkt_state_t    state_next;
    logic [IW-1:0] lat_tid;
    logic [DW-1:0] lat_tdest;
    logic [BW-1:0] pkt_beats;
    logic          id_diff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (hs) begin
            state_next = last ? ST_IDLE : ST_IN_PKT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_tid   <= '0;
            lat_tdest <= '0;
        end else if (hs && !last && (state == ST_IDLE)) begin
            lat_tid   <= tid;
            lat_tdest <= tdest;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_beats <= '0;
        end else if (hs) begin
            if (last) begin
                pkt_beats <= '0;
            end else if (pkt_beats != BEAT_SAT) begin
                pkt_beats <= pkt_beats + 1'b1;
            end
        end
    end

    always_comb begin
        in_packet      = (state == ST_IN_PKT);
        id_diff        = ((ID_WIDTH > 0) && (tid != lat_tid)) ||
                         ((DEST_WIDTH > 0) && (tdest != lat_tdest));
        err_interleave = (ALLOW_INTERLEAVE == 0) && (state == ST_IN_PKT) && hs && id_diff;
        err_too_long   = (MAX_BEATS > 0) && hs && (pkt_beats == BEAT_SAT);
    end

endmodule

// File: rtl/axis_protocol_checker.sv
// rtl/axis_protocol_checker.sv - passive stream protocol checker; AXIS_CHECKER_STALL_TIMEOUT_EN enables the stall timeout
module axis_protocol_checker
    import axis_checker_pkg::*;
#(
    parameter int BYTE_WIDTH       = 4,
    parameter int ID_WIDTH         = 0,
    parameter int DEST_WIDTH       = 0,
    parameter int USER_WIDTH       = 0,
    parameter int MAX_BEATS        = 0,
    parameter int ALLOW_INTERLEAVE = 1,
    parameter int CNT_WIDTH        = 32,
    parameter int STALL_LIMIT      = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    axis_protocol_checker_if.monitor mon,
    input  logic                  err_clear,
    output logic [ERR_COUNT-1:0]  err_flags,
    output logic [ERR_COUNT-1:0]  err_first,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  in_packet
);

    localparam int IW = max1(ID_WIDTH);
    localparam int DW = max1(DEST_WIDTH);
    localparam int UW = max1(USER_WIDTH);

    logic                    prev_ok;
    logic                    prev_valid;
    logic                    prev_ready;
    logic                    p_tlast;
    logic [8*BYTE_WIDTH-1:0] p_tdata;
    logic [BYTE_WIDTH-1:0]   p_tstrb;
    logic [BYTE_WIDTH-1:0]   p_tkeep;
    logic [IW-1:0]           p_tid;
    logic [DW-1:0]           p_tdest;
    logic [UW-1:0]           p_tuser;

    logic                 hs;
    logic                 stalled_prev;
    logic                 payload_changed;
    logic                 too_long;
    logic                 interleave;
    logic                 stall_viol;
    logic [ERR_COUNT-1:0] viol;
    logic [ERR_COUNT-1:0] flags_base;
    logic [ERR_COUNT-1:0] first_base;

    assign hs = mon.tvalid && mon.tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_ok    <= 1'b0;
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            p_tlast    <= 1'b0;
            p_tdata    <= '0;
            p_tstrb    <= '0;
            p_tkeep    <= '0;
            p_tid      <= '0;
            p_tdest    <= '0;
            p_tuser    <= '0;
        end else begin
            prev_ok    <= 1'b1;
            prev_valid <= mon.tvalid;
            prev_ready <= mon.tready;
            p_tlast    <= mon.tlast;
            p_tdata    <= mon.tdata;
            p_tstrb    <= mon.tstrb;
            p_tkeep    <= mon.tkeep;
            p_tid      <= mon.tid;
            p_tdest    <= mon.tdest;
            p_tuser    <= mon.tuser;
        end
    end

    axis_pkt_tracker #(
        .ID_WIDTH         (ID_WIDTH),
        .DEST_WIDTH       (DEST_WIDTH),
        .MAX_BEATS        (MAX_BEATS),
        .ALLOW_INTERLEAVE (ALLOW_INTERLEAVE)
    ) u_tracker (
        .clk            (clk),
        .reset          (reset),
        .hs             (hs),
        .last           (mon.tlast),
        .tid            (mon.tid),
        .tdest          (mon.tdest),
        .in_packet      (in_packet),
        .err_interleave (interleave),
        .err_too_long   (too_long)
    );

`ifdef AXIS_CHECKER_STALL_TIMEOUT_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_SAT  = SW'(STALL_LIMIT);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

    logic [SW-1:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!mon.tvalid || mon.tready) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_SAT) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Fires on the stalled edge that brings the run length up to STALL_LIMIT.
    assign stall_viol = mon.tvalid && !mon.tready && (stall_cnt >= STALL_LAST);
`else
    assign stall_viol = 1'b0;
`endif

    always_comb begin
        stalled_prev    = prev_ok && prev_valid && !prev_ready;
        payload_changed = (mon.tdata != p_tdata) || (mon.tstrb != p_tstrb) ||
                          (mon.tkeep != p_tkeep) || (mon.tlast != p_tlast) ||
                          ((ID_WIDTH > 0)   && (mon.tid   != p_tid))   ||
                          ((DEST_WIDTH > 0) && (mon.tdest != p_tdest)) ||
                          ((USER_WIDTH > 0) && (mon.tuser != p_tuser));
        viol                       = '0;
        viol[ERR_VALID_DROP]       = stalled_prev && !mon.tvalid;
        viol[ERR_PAYLOAD_UNSTABLE] = stalled_prev && payload_changed;
        viol[ERR_STRB_NO_KEEP]     = mon.tvalid && (|(mon.tstrb & ~mon.tkeep));
        viol[ERR_PKT_TOO_LONG]     = too_long;
        viol[ERR_ID_INTERLEAVE]    = interleave;
        viol[ERR_STALL_TIMEOUT]    = stall_viol;
        // A clear in the same cycle as a new violation leaves only the new bits.
        flags_base = err_clear ? '0 : err_flags;
        first_base = err_clear ? '0 : err_first;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flags <= '0;
            err_first <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_flags <= flags_base | viol;
            err_first <= (first_base == '0) ? viol : first_base;
            err_pulse <= |(viol & ~flags_base);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count <= '0;
            pkt_count  <= '0;
        end else if (hs) begin
            if (beat_count != '1) begin
                beat_count <= beat_count + 1'b1;
            end
            if (mon.tlast && (pkt_count != '1)) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

endmodule
